// File: rtl/ineq_sweep_ctrl_if.sv
// Host/evaluator bundle for the standard-form sweep sequencer.
// slave  = the sequencer itself, master = host plus evaluator side.
interface ineq_sweep_ctrl_if #(
    parameter int NUM_W = 4,
    parameter int OUT_W = 3
);
    logic                          start;
    logic                          abort;
    logic [OUT_W*(2**NUM_W)-1:0]   exp_table;
    logic [NUM_W-1:0]              num;
    logic [OUT_W-1:0]              out_in;
    logic                          busy;
    logic                          done;
    logic                          pass;
    logic [NUM_W:0]                err_count;
    logic                          fail_valid;
    logic [NUM_W-1:0]              first_fail_num;

    modport slave (
        input  start, abort, exp_table, out_in,
        output num, busy, done, pass, err_count, fail_valid, first_fail_num
    );

    modport master (
        output start, abort, exp_table, out_in,
        input  num, busy, done, pass, err_count, fail_valid, first_fail_num
    );
endinterface

// File: rtl/ineq_sweep_ctrl.sv
// Exhaustive self-check sequencer for a combinational standard-form evaluator.
// Drives every input code, waits SETTLE cycles, samples the evaluator output
// and compares it with the expected truth table.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for start; results of the last sweep are held
// ST_SETTLE | num driven, settle counter running down to 1
// ST_SAMPLE | compare out_in with the expected entry, then advance or finish
module ineq_sweep_ctrl #(
    parameter int NUM_W  = 4,
    parameter int OUT_W  = 3,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    ineq_sweep_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    localparam logic [3:0]       SETTLE_L = 4'(SETTLE);
    localparam logic [NUM_W-1:0] LAST_NUM = {NUM_W{1'b1}};
    localparam logic [NUM_W-1:0] NUM_ONE  = NUM_W'(1);
    localparam logic [NUM_W:0]   ERR_ONE  = (NUM_W+1)'(1);
    // With no settle time the next code is sampled on the very next edge.
    localparam state_t           ST_AFTER_LOAD = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [NUM_W-1:0] num_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [NUM_W:0]   err_q;
    logic             fv_q;
    logic [NUM_W-1:0] ff_q;

    logic [OUT_W-1:0] exp_sel;
    logic             mismatch;

    // Expected entry for the code currently on the evaluator input.
    assign exp_sel  = bus.exp_table[int'(num_q)*OUT_W +: OUT_W];
    assign mismatch = (bus.out_in != exp_sel);

    // Sweep sequencer: state, settle timer, code drive and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            num_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ff_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // abort has priority: start+abort together leaves results untouched
                    if (bus.start && !bus.abort) begin
                        num_q   <= '0;
                        busy_q  <= 1'b1;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        fv_q    <= 1'b0;
                        ff_q    <= '0;
                        cnt_q   <= SETTLE_L;
                        state_q <= ST_AFTER_LOAD;
                    end
                end

                ST_SETTLE: begin
                    if (bus.abort) begin
                        busy_q  <= 1'b0;
                        num_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q <= ST_SAMPLE;
                        end
                    end
                end

                ST_SAMPLE: begin
                    if (bus.abort) begin
                        // the comparison on an aborting edge is discarded
                        busy_q  <= 1'b0;
                        num_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        if (mismatch) begin
                            err_q <= err_q + ERR_ONE;
                            if (!fv_q) begin
                                fv_q <= 1'b1;
                                ff_q <= num_q;
                            end
                        end
                        if (num_q == LAST_NUM) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_q == '0) && !mismatch;
                            num_q   <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            num_q   <= num_q + NUM_ONE;
                            cnt_q   <= SETTLE_L;
                            state_q <= ST_AFTER_LOAD;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    num_q   <= '0;
                end
            endcase
        end
    end

    assign bus.num            = num_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_count      = err_q;
    assign bus.fail_valid     = fv_q;
    assign bus.first_fail_num = ff_q;

endmodule

// File: tb/tb_ineq_sweep_ctrl.sv
// Bench for ineq_sweep_ctrl: two instances (settle 2 and settle 0) driven
// by a random evaluator truth table and compared against a table-level model.
module tb_ineq_sweep_ctrl;

    localparam int NW = 4;
    localparam int OW = 3;
    localparam int NC = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic [OW-1:0]    eval_tbl [NC];
    logic [OW*NC-1:0] exp_tbl;

    logic start_v [2];
    logic abort_v [2];

    logic          busy_o [2];
    logic          done_o [2];
    logic          pass_o [2];
    logic [NW-1:0] num_o  [2];
    logic [NW:0]   err_o  [2];
    logic          fv_o   [2];
    logic [NW-1:0] ff_o   [2];

    int n_assert = 0;
    int n_fail   = 0;

    ineq_sweep_ctrl_if #(.NUM_W(NW), .OUT_W(OW)) bus_a ();
    ineq_sweep_ctrl_if #(.NUM_W(NW), .OUT_W(OW)) bus_b ();

    ineq_sweep_ctrl #(.NUM_W(NW), .OUT_W(OW), .SETTLE(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    ineq_sweep_ctrl #(.NUM_W(NW), .OUT_W(OW), .SETTLE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    assign bus_a.start     = start_v[0];
    assign bus_a.abort     = abort_v[0];
    assign bus_a.exp_table = exp_tbl;
    assign bus_a.out_in    = eval_tbl[bus_a.num];
    assign bus_b.start     = start_v[1];
    assign bus_b.abort     = abort_v[1];
    assign bus_b.exp_table = exp_tbl;
    assign bus_b.out_in    = eval_tbl[bus_b.num];

    assign busy_o[0] = bus_a.busy;  assign busy_o[1] = bus_b.busy;
    assign done_o[0] = bus_a.done;  assign done_o[1] = bus_b.done;
    assign pass_o[0] = bus_a.pass;  assign pass_o[1] = bus_b.pass;
    assign num_o[0]  = bus_a.num;   assign num_o[1]  = bus_b.num;
    assign err_o[0]  = bus_a.err_count;      assign err_o[1] = bus_b.err_count;
    assign fv_o[0]   = bus_a.fail_valid;     assign fv_o[1]  = bus_b.fail_valid;
    assign ff_o[0]   = bus_a.first_fail_num; assign ff_o[1]  = bus_b.first_fail_num;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Table-level reference: mismatches among the first n_codes codes.
    task automatic model(input int n_codes, output int err, output int first);
        err   = 0;
        first = -1;
        for (int k = 0; k < n_codes; k++) begin
            if (eval_tbl[k] !== exp_tbl[k*OW +: OW]) begin
                err++;
                if (first < 0) first = k;
            end
        end
    endtask

    task automatic set_exact();
        for (int k = 0; k < NC; k++) exp_tbl[k*OW +: OW] = eval_tbl[k];
    endtask

    task automatic corrupt(input int k);
        logic [OW-1:0] flip;
        flip = OW'($urandom_range(1, (1 << OW) - 1));
        exp_tbl[k*OW +: OW] = eval_tbl[k] ^ flip;
    endtask

    // Launch a sweep and check busy/done/num against the ideal timeline:
    // code c is driven for edges c*(s+1) .. c*(s+1)+s, done at edge NC*(s+1).
    // stop_at>0 returns #1 after edge stop_at-1 so the caller can abort/reset.
    task automatic run_sweep(input int d, input int s, input int pulse_at, input int stop_at);
        int total, t_last, bad;
        logic e_busy, e_done;
        logic [NW-1:0] e_num;
        total  = NC * (s + 1);
        t_last = (stop_at > 0) ? stop_at - 1 : total + 1;
        bad    = 0;
        start_v[d] = 1'b1;
        for (int t = 0; t <= t_last; t++) begin
            @(posedge clk); #1;
            start_v[d] = (t == pulse_at);
            e_busy = (t < total);
            e_done = (t == total);
            e_num  = (t < total) ? NW'(t / (s + 1)) : '0;
            if (busy_o[d] !== e_busy || done_o[d] !== e_done || num_o[d] !== e_num) bad++;
        end
        chk($sformatf("timeline_d%0d_s%0d", d, s), bad, 0);
    endtask

    task automatic chk_results(input string tag, input int d, input int n_codes, input logic full);
        int e_err, e_first;
        model(n_codes, e_err, e_first);
        chk({tag, "_err"},  err_o[d], e_err);
        chk({tag, "_fv"},   fv_o[d], (e_err > 0));
        chk({tag, "_ff"},   ff_o[d], (e_first < 0) ? 0 : e_first);
        chk({tag, "_pass"}, pass_o[d], full && (e_err == 0));
    endtask

    initial begin
        int bad, saved_err;
        rst_n = 1'b0;
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        abort_v[0] = 1'b0; abort_v[1] = 1'b0;
        for (int k = 0; k < NC; k++) eval_tbl[k] = OW'($urandom);
        eval_tbl[2] = '0;
        set_exact();

        #12;
        chk("rst_num",  num_o[0], 0);
        chk("rst_busy", busy_o[0], 0);
        chk("rst_done", done_o[0], 0);
        chk("rst_pass", pass_o[0], 0);
        chk("rst_err",  err_o[0], 0);
        chk("rst_fv",   fv_o[0], 0);
        chk("rst_ff",   ff_o[0], 0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        // clean table, both settle settings
        run_sweep(0, 2, -1, 0);
        chk_results("clean_a", 0, NC, 1'b1);
        run_sweep(1, 0, -1, 0);
        chk_results("clean_b", 1, NC, 1'b1);

        // codes 5 and 11 wrong
        set_exact(); corrupt(5); corrupt(11);
        run_sweep(0, 2, -1, 0);
        chk_results("two_bad", 0, NC, 1'b1);

        // fully inverted table: every code fails, count reaches 2**NUM_W
        for (int k = 0; k < NC; k++) exp_tbl[k*OW +: OW] = ~eval_tbl[k];
        run_sweep(1, 0, -1, 0);
        chk_results("inv_b", 1, NC, 1'b1);
        run_sweep(0, 2, -1, 0);
        chk_results("inv_a", 0, NC, 1'b1);

        // random corruption patterns on the fast instance
        for (int r = 0; r < 4; r++) begin
            set_exact();
            for (int k = 0; k < NC; k++) if ($urandom_range(0, 3) == 0) corrupt(k);
            run_sweep(1, 0, -1, 0);
            chk_results($sformatf("rand%0d", r), 1, NC, 1'b1);
        end

        // abort on edge 10 after start: codes 0..2 have been sampled
        set_exact(); corrupt(1);
        run_sweep(0, 2, -1, 10);
        abort_v[0] = 1'b1;
        @(posedge clk); #1;
        abort_v[0] = 1'b0;
        chk("abort_busy", busy_o[0], 0);
        chk("abort_num",  num_o[0], 0);
        chk("abort_done", done_o[0], 0);
        chk_results("abort", 0, 9 / 3, 1'b0);
        bad = 0;
        for (int t = 0; t < 60; t++) begin
            @(posedge clk); #1;
            if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b0) bad++;
        end
        chk("abort_quiet", bad, 0);

        // start together with abort in idle: nothing starts, nothing clears
        saved_err = int'(err_o[0]);
        start_v[0] = 1'b1; abort_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0; abort_v[0] = 1'b0;
        @(posedge clk); #1;
        chk("sa_busy", busy_o[0], 0);
        chk("sa_err",  err_o[0], saved_err);
        chk("sa_fv",   fv_o[0], 1);

        // mid-sweep start is ignored, then async reset at cycle 20
        set_exact(); corrupt(3);
        run_sweep(0, 2, 5, 21);
        chk_results("pre_rst", 0, 20 / 3, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy_o[0], 0);
        chk("arst_num",  num_o[0], 0);
        chk("arst_err",  err_o[0], 0);
        chk("arst_fv",   fv_o[0], 0);
        chk("arst_ff",   ff_o[0], 0);
        @(posedge clk); #3 rst_n = 1'b1;
        bad = 0;
        for (int t = 0; t < 6; t++) begin
            @(posedge clk); #1;
            if (busy_o[0] !== 1'b0 || num_o[0] !== '0 || done_o[0] !== 1'b0) bad++;
        end
        chk("post_rst_idle", bad, 0);
        run_sweep(0, 2, -1, 0);
        chk_results("post_rst", 0, NC, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
